// File: rtl/seq_add_sub_unit_pkg.sv
// Shared types for the sequential add/sub unit.
// FSM state encoding and word-mode width.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int WORD_W = 32;

  // Number of chunks needed to cover a given operand width.
  function automatic int chunks_for(
    input int width,
    input int chunk
  );
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_add_sub_unit_if.sv
// Valid/ready operand and result bundle of the
// sequential add/sub unit.
interface seq_add_sub_unit_if #(
  parameter int N = 64
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         sub;
  logic         word;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid,
    output A,
    output B,
    output sub,
    output word,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  S,
    input  cout,
    input  ovf,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  sub,
    input  word,
    input  out_ready,
    output in_ready,
    output out_valid,
    output S,
    output cout,
    output ovf,
    output zero
  );

endinterface

// File: rtl/seq_add_sub_unit_chunk.sv
// One W-bit slice of the adder: optional B inversion,
// carry-in, carry-out and carry into the MSB.
module chunk_add_sub #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] bx;
  logic [W:0]   t;

  // Slice sum; carry into the MSB recovered from the sum bit.
  always_comb begin
    bx    = sub ? ~b : b;
    t     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    sum   = t[W-1:0];
    cout  = t[W];
    c_msb = a[W-1] ^ bx[W-1] ^ t[W-1];
  end

endmodule

// File: rtl/seq_add_sub_unit.sv
// Multi-cycle N-bit add/sub, CHUNK bits per cycle,
// with ADDW/SUBW word mode and carry/ovf/zero flags.
module seq_add_sub_unit #(
  parameter int N     = 64,
  parameter int CHUNK = 16
) (
  input logic              clk,
  input logic              rst_n,
  seq_add_sub_unit_if.slave bus
);

  import add_sub_pkg::*;

  localparam int NCH = chunks_for(N, CHUNK);
  localparam int NCW = chunks_for(WORD_W, CHUNK);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [KW-1:0] K_FULL = KW'(NCH - 1);
  localparam logic [KW-1:0] K_WORD = KW'(NCW - 1);

  state_t state_q;
  state_t state_d;

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     s_q;
  logic             sub_q;
  logic             word_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [KW-1:0]    k_q;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] sum_ch;
  logic             co_ch;
  logic             cm_ch;
  logic             k_last;
  logic             accept;
  logic [N-1:0]     s_ins;
  logic [N-1:0]     s_fin;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign sh     = 32'(k_q) * 32'(CHUNK);
  assign a_ch   = CHUNK'(a_q >> sh);
  assign b_ch   = CHUNK'(b_q >> sh);
  assign k_last = (k_q == (word_q ? K_WORD : K_FULL));

  chunk_add_sub #(
    .W(CHUNK)
  ) u_chunk (
    .a    (a_ch),
    .b    (b_ch),
    .sub  (sub_q),
    .cin  (c_q),
    .sum  (sum_ch),
    .cout (co_ch),
    .c_msb(cm_ch)
  );

  // Insert the fresh chunk; sign-extend on the last word chunk.
  always_comb begin
    s_ins = (s_q & ~(N'({CHUNK{1'b1}}) << sh))
          | (N'(sum_ch) << sh);
    s_fin = s_ins;
    if (word_q) begin
      s_fin[N-1:WORD_W] = {(N-WORD_W){s_ins[WORD_W-1]}};
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = RUN;
      RUN:  if (k_last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, chunk walk and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      sub_q  <= 1'b0;
      word_q <= 1'b0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      k_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            sub_q  <= bus.sub;
            word_q <= bus.word;
            c_q    <= bus.sub;
            k_q    <= '0;
          end
        end
        RUN: begin
          s_q <= k_last ? s_fin : s_ins;
          c_q <= co_ch;
          k_q <= k_q + KW'(1);
          if (k_last) begin
            cout_q <= co_ch;
            ovf_q  <= co_ch ^ cm_ch;
            zero_q <= (s_fin == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Self-checking bench for seq_add_sub_unit:
// directed vectors, random ops, backpressure, reset abort.
module tb_seq_add_sub_unit;

  localparam int N     = 64;
  localparam int CHUNK = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  seq_add_sub_unit_if #(.N(N)) bus ();

  seq_add_sub_unit #(
    .N(N),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference: plain modular arithmetic and sign rules.
  task automatic model(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sb,
    input  logic        wd,
    output logic [63:0] s,
    output logic        co,
    output logic        ov,
    output logic        z
  );
    logic [64:0] t;
    logic [32:0] t32;
    logic [31:0] r;
    if (wd) begin
      if (sb) begin
        r  = a[31:0] - b[31:0];
        co = (a[31:0] >= b[31:0]);
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end else begin
        t32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        r   = t32[31:0];
        co  = t32[32];
        ov  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      s = {{32{r[31]}}, r};
    end else begin
      if (sb) begin
        s  = a - b;
        co = (a >= b);
        ov = (a[63] != b[63]) && (s[63] != a[63]);
      end else begin
        t  = {1'b0, a} + {1'b0, b};
        s  = t[63:0];
        co = t[64];
        ov = (a[63] == b[63]) && (s[63] != a[63]);
      end
    end
    z = (s == 64'd0);
  endtask

  // Drive one op and collect its result; lat=0 on timeout.
  task automatic run_op(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sb,
    input  logic        wd,
    output logic [63:0] s,
    output logic        co,
    output logic        ov,
    output logic        z,
    output int          lat
  );
    @(negedge clk);
    bus.A         = a;
    bus.B         = b;
    bus.sub       = sb;
    bus.word      = wd;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
    end
    s  = bus.S;
    co = bus.cout;
    ov = bus.ovf;
    z  = bus.zero;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sub       = 1'b0;
    bus.word      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_hs: got v=%b r=%b want v=0 r=1",
               bus.out_valid, bus.in_ready);
    end
    nchk++;
    if (bus.S !== 64'd0) begin
      nerr++;
      $display("FAIL reset_s: got %h want 0", bus.S);
    end
    nchk++;
    if ({bus.cout, bus.ovf, bus.zero} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.cout, bus.ovf, bus.zero});
    end
  endtask

  task automatic test_directed();
    logic [63:0] va [5];
    logic [63:0] vb [5];
    logic [63:0] vs [5];
    logic [4:0]  vsub;
    logic [4:0]  vwd;
    logic [2:0]  vfl [5];
    int          vlat [5];
    logic [63:0] s;
    logic        co, ov, z;
    int          lat;
    va[0] = 64'h0000_0000_FFFF_FFFF; vb[0] = 64'd1;
    vs[0] = 64'h0000_0001_0000_0000; vfl[0] = 3'b000;
    va[1] = 64'h1234_5678_9ABC_DEF0; vb[1] = va[1];
    vs[1] = 64'd0;                   vfl[1] = 3'b101;
    va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1;
    vs[2] = 64'h8000_0000_0000_0000; vfl[2] = 3'b010;
    va[3] = 64'd0;                   vb[3] = 64'd1;
    vs[3] = 64'hFFFF_FFFF_FFFF_FFFF; vfl[3] = 3'b000;
    va[4] = 64'hDEAD_0000_7FFF_FFFF; vb[4] = 64'd1;
    vs[4] = 64'hFFFF_FFFF_8000_0000; vfl[4] = 3'b010;
    vsub = 5'b01010;
    vwd  = 5'b10000;
    vlat[0] = 5; vlat[1] = 5; vlat[2] = 5;
    vlat[3] = 5; vlat[4] = 3;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vsub[i], vwd[i], s, co, ov, z, lat);
      nchk++;
      if (s !== vs[i]) begin
        nerr++;
        $display("FAIL dir%0d_s: got %h want %h", i, s, vs[i]);
      end
      nchk++;
      if ({co, ov, z} !== vfl[i]) begin
        nerr++;
        $display("FAIL dir%0d_flags: got %b want %b",
                 i, {co, ov, z}, vfl[i]);
      end
      nchk++;
      if (lat != vlat[i]) begin
        nerr++;
        $display("FAIL dir%0d_lat: got %0d want %0d",
                 i, lat, vlat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, s, es;
    logic        sb, wd, co, ov, z, eco, eov, ez;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) b = ~a;
      sb = 1'($urandom);
      wd = 1'($urandom);
      model(a, b, sb, wd, es, eco, eov, ez);
      run_op(a, b, sb, wd, s, co, ov, z, lat);
      nchk++;
      if (s !== es || {co, ov, z} !== {eco, eov, ez}) begin
        nerr++;
        $display("FAIL rnd%0d: got %h/%b want %h/%b",
                 i, s, {co, ov, z}, es, {eco, eov, ez});
      end
      nchk++;
      if (lat != (wd ? 3 : 5)) begin
        nerr++;
        $display("FAIL rnd%0d_lat: got %0d want %0d",
                 i, lat, wd ? 3 : 5);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a1, b1, a2, b2, e1, e2;
    logic        c1, o1, z1, c2, o2, z2;
    int          lat;
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    model(a1, b1, 1'b0, 1'b0, e1, c1, o1, z1);
    model(a2, b2, 1'b1, 1'b0, e2, c2, o2, z2);
    @(negedge clk);
    bus.A         = a1;
    bus.B         = b1;
    bus.sub       = 1'b0;
    bus.word      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
    end
    nchk++;
    if (lat != 5) begin
      nerr++;
      $display("FAIL bp_lat1: got %0d want 5", lat);
    end
    bus.A        = a2;
    bus.B        = b2;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      nchk++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
          || bus.S !== e1
          || {bus.cout, bus.ovf, bus.zero} !== {c1, o1, z1}) begin
        nerr++;
        $display("FAIL bp_hold%0d: got v=%b r=%b %h want v=1 r=0 %h",
                 i, bus.out_valid, bus.in_ready, bus.S, e1);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: got r=%b v=%b want r=1 v=0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
    end
    nchk++;
    if (lat != 5 || bus.S !== e2
        || {bus.cout, bus.ovf, bus.zero} !== {c2, o2, z2}) begin
      nerr++;
      $display("FAIL bp_op2: got lat=%0d %h want lat=5 %h",
               lat, bus.S, e2);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] s;
    logic        co, ov, z, seen;
    int          lat;
    @(negedge clk);
    bus.A         = 64'hFFFF_0000_1234_5678;
    bus.B         = 64'h0000_FFFF_0000_0001;
    bus.sub       = 1'b0;
    bus.word      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (bus.out_valid !== 1'b0 || bus.S !== 64'd0
        || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid: got v=%b r=%b %h want v=0 r=1 0",
               bus.out_valid, bus.in_ready, bus.S);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    nchk++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL rst_discard: got out_valid=1 want 0");
    end
    run_op(64'd5, 64'd3, 1'b1, 1'b0, s, co, ov, z, lat);
    nchk++;
    if (s !== 64'd2 || co !== 1'b1 || lat != 5) begin
      nerr++;
      $display("FAIL rst_next: got %h c=%b lat=%0d want 2 c=1 lat=5",
               s, co, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
